// File: rtl/mti_pkg.sv
// mti_pkg: shared definitions for multi_threshold_integrator.
//   - FSM state encoding (IDLE=0, RUNNING=1, TRIPPED=2)
//   - width helpers for chunk sums and running totals
//   - offset-binary magnitude helper
package mti_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    TRIPPED = 2'd2
  } state_e;

  // One chunk accumulates 2^chunk_log2 magnitudes of sample_w bits each.
  function automatic int chunk_w(input int sample_w, input int chunk_log2);
    return sample_w + chunk_log2;
  endfunction

  // A window holds 2^depth_log2 chunks.
  function automatic int total_w(input int sample_w, input int chunk_log2,
                                 input int depth_log2);
    return sample_w + chunk_log2 + depth_log2;
  endfunction

  // Distance of an offset-binary code from mid-scale. Works on the low w bits
  // of v; callers truncate the result back to w bits.
  function automatic logic [31:0] offset_mag(input logic [31:0] v, input int w);
    logic [31:0] half;
    half = 32'd1 << (w - 1);
    if (v[w-1]) return v - half;
    else        return half - v;
  endfunction

endpackage

// File: rtl/multi_threshold_integrator_channel.sv
// mti_channel: per-channel datapath of multi_threshold_integrator.
// Optional feature macro: MULTI_THRESHOLD_INTEGRATOR_PEAK_EN (adds peak output).
// Ports:
//   clk, rst          clock, async active-high reset
//   clr               hold/clear sums, total, flag (next state is IDLE)
//   run               accumulate this cycle (RUNNING or TRIPPED)
//   strobe, sample    latch magnitude of an offset-binary sample
//   boundary          last cycle of a chunk
//   wr_ptr            shared ring write pointer
//   ring_full         ring has filled once, eviction is live
//   limit             trip limit in total units
//   hit               this cycle's total update exceeds limit
//   over              sticky trip flag
//   peak              (optional) max running total since entering RUNNING
module mti_channel
  import mti_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int CHUNK_LOG2 = 10,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clr,
  input  logic                                     run,
  input  logic                                     strobe,
  input  logic [SAMPLE_W-1:0]                      sample,
  input  logic                                     boundary,
  input  logic [DEPTH_LOG2-1:0]                    wr_ptr,
  input  logic                                     ring_full,
  input  logic [SAMPLE_W+CHUNK_LOG2+DEPTH_LOG2-1:0] limit,
  output logic                                     hit,
  output logic                                     over
`ifdef MULTI_THRESHOLD_INTEGRATOR_PEAK_EN
  ,
  output logic [SAMPLE_W+CHUNK_LOG2+DEPTH_LOG2-1:0] peak
`endif
);

  localparam int CHUNK_W = chunk_w(SAMPLE_W, CHUNK_LOG2);
  localparam int TOTAL_W = total_w(SAMPLE_W, CHUNK_LOG2, DEPTH_LOG2);
  localparam int DEPTH   = 1 << DEPTH_LOG2;

  logic [SAMPLE_W-1:0] mag_q, mag_d;
  logic [CHUNK_W-1:0]  chunk_q, chunk_d;
  logic [CHUNK_W-1:0]  new_q, new_d;
  logic [CHUNK_W-1:0]  evict_q, evict_d;
  logic                upd_q, upd_d;
  logic [TOTAL_W-1:0]  total_q, total_d;
  logic                over_q, over_d;
  logic [CHUNK_W-1:0]  chunk_sum;
  logic [TOTAL_W-1:0]  total_next;
  logic [CHUNK_W-1:0]  ring_q [DEPTH];

  always_comb begin
    mag_d   = strobe ? SAMPLE_W'(offset_mag(32'(sample), SAMPLE_W)) : mag_q;
    chunk_sum = chunk_q + CHUNK_W'(mag_q);

    chunk_d = chunk_q;
    new_d   = new_q;
    evict_d = evict_q;
    upd_d   = 1'b0;
    if (clr) begin
      chunk_d = '0;
      new_d   = '0;
      evict_d = '0;
    end else if (run) begin
      if (boundary) begin
        // Completed chunk goes to the ring; the slot it overwrites is the
        // chunk leaving the window once the ring has wrapped.
        chunk_d = '0;
        new_d   = chunk_sum;
        evict_d = ring_full ? ring_q[wr_ptr] : '0;
        upd_d   = 1'b1;
      end else begin
        chunk_d = chunk_sum;
      end
    end

    total_next = total_q + TOTAL_W'(new_q) - TOTAL_W'(evict_q);
    // Deliberately independent of clr: clr is derived from the next state,
    // which in turn depends on hit.
    hit     = upd_q && (total_next > limit);
    total_d = clr ? '0 : (upd_q ? total_next : total_q);
    over_d  = clr ? 1'b0 : (over_q | hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q   <= '0;
      chunk_q <= '0;
      new_q   <= '0;
      evict_q <= '0;
      upd_q   <= 1'b0;
      total_q <= '0;
      over_q  <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      chunk_q <= chunk_d;
      new_q   <= new_d;
      evict_q <= evict_d;
      upd_q   <= upd_d;
      total_q <= total_d;
      over_q  <= over_d;
    end
  end

  // Ring contents are qualified by ring_full, so they need no reset.
  always_ff @(posedge clk) begin
    if (run && boundary && !clr) ring_q[wr_ptr] <= chunk_sum;
  end

  assign over = over_q;

`ifdef MULTI_THRESHOLD_INTEGRATOR_PEAK_EN
  logic [TOTAL_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (clr)                                peak_d = '0;
    else if (upd_q && total_next > peak_q)  peak_d = total_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

endmodule

// File: rtl/multi_threshold_integrator.sv
// multi_threshold_integrator: per-channel sliding-window magnitude integrator
// with a shared average-magnitude trip limit.
// Optional feature macro: MULTI_THRESHOLD_INTEGRATOR_PEAK_EN (adds
// peak_total_concat, per-channel max running total since entering RUNNING).
// Ports:
//   clk, rst             clock, async active-high reset
//   enable               run request; low returns to IDLE
//   threshold_average    per-cycle average magnitude limit (latched on start)
//   value_in_concat      NUM_CH offset-binary samples, ch i at [SW*(i+1)-1 -: SW]
//   value_ready_concat   per-channel sample strobe
//   setup_done           high in RUNNING and TRIPPED
//   channel_over         sticky per-channel trip flags
//   over_threshold       OR of channel_over
module multi_threshold_integrator
  import mti_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int SAMPLE_W   = 16,
  parameter int CHUNK_LOG2 = 10,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [SAMPLE_W-1:0]        threshold_average,
  input  logic [NUM_CH*SAMPLE_W-1:0] value_in_concat,
  input  logic [NUM_CH-1:0]          value_ready_concat,
  output logic                       setup_done,
  output logic [NUM_CH-1:0]          channel_over,
  output logic                       over_threshold
`ifdef MULTI_THRESHOLD_INTEGRATOR_PEAK_EN
  ,
  output logic [NUM_CH*(SAMPLE_W+CHUNK_LOG2+DEPTH_LOG2)-1:0] peak_total_concat
`endif
);

  localparam int TOTAL_W = total_w(SAMPLE_W, CHUNK_LOG2, DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] FILL_MAX = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  state_e                state_q, state_d;
  logic [CHUNK_LOG2-1:0] timer_q, timer_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic [SAMPLE_W-1:0]   thr_q, thr_d;
  logic                  setup_done_q, setup_done_d;

  logic                  run;
  logic                  clr;
  logic                  boundary;
  logic                  ring_full;
  logic [TOTAL_W-1:0]    limit;
  logic [NUM_CH-1:0]     hit_vec;

  assign run       = (state_q != IDLE);
  assign boundary  = run && (timer_q == '1);
  assign ring_full = (fill_q == FILL_MAX);
  assign limit     = TOTAL_W'(thr_q) << (CHUNK_LOG2 + DEPTH_LOG2);

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUNNING;
          thr_d   = threshold_average;
        end
      end
      RUNNING: begin
        // Dropping enable wins over a trip detected in the same cycle.
        if (!enable)        state_d = IDLE;
        else if (|hit_vec)  state_d = TRIPPED;
      end
      TRIPPED: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    clr = (state_d == IDLE);

    timer_d  = clr ? '0 : (run ? timer_q + 1'b1 : timer_q);
    wr_ptr_d = clr ? '0 : (boundary ? wr_ptr_q + 1'b1 : wr_ptr_q);
    fill_d   = fill_q;
    if (clr)                          fill_d = '0;
    else if (boundary && !ring_full)  fill_d = fill_q + 1'b1;

    setup_done_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      thr_q        <= '0;
      setup_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      thr_q        <= thr_d;
      setup_done_q <= setup_done_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mti_channel #(
      .SAMPLE_W   (SAMPLE_W),
      .CHUNK_LOG2 (CHUNK_LOG2),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .run       (run),
      .strobe    (value_ready_concat[i]),
      .sample    (value_in_concat[SAMPLE_W*(i+1)-1 -: SAMPLE_W]),
      .boundary  (boundary),
      .wr_ptr    (wr_ptr_q),
      .ring_full (ring_full),
      .limit     (limit),
      .hit       (hit_vec[i]),
      .over      (channel_over[i])
`ifdef MULTI_THRESHOLD_INTEGRATOR_PEAK_EN
      ,
      .peak      (peak_total_concat[TOTAL_W*(i+1)-1 -: TOTAL_W])
`endif
    );
  end

  assign setup_done     = setup_done_q;
  assign over_threshold = |channel_over;

endmodule

// File: tb/tb_multi_threshold_integrator.sv
// Directed bench for multi_threshold_integrator with NUM_CH=2, SAMPLE_W=16,
// CHUNK_LOG2=2, DEPTH_LOG2=2 (4-cycle chunks, 16-cycle window).
// Cycle references below: E0 is the edge that moves IDLE->RUNNING; after
// step(k) the bench sits just past edge Ek.
module tb_multi_threshold_integrator;

  localparam int NUM_CH = 2;
  localparam int SW     = 16;
  localparam int CL     = 2;
  localparam int DL     = 2;
  localparam int TW     = SW + CL + DL;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic [SW-1:0]        threshold_average;
  logic [NUM_CH*SW-1:0] value_in_concat;
  logic [NUM_CH-1:0]    value_ready_concat;
  logic                 setup_done;
  logic [NUM_CH-1:0]    channel_over;
  logic                 over_threshold;
`ifdef MULTI_THRESHOLD_INTEGRATOR_PEAK_EN
  logic [NUM_CH*TW-1:0] peak_total_concat;
`endif

  int n_chk = 0;
  int n_bad = 0;

  multi_threshold_integrator #(
    .NUM_CH     (NUM_CH),
    .SAMPLE_W   (SW),
    .CHUNK_LOG2 (CL),
    .DEPTH_LOG2 (DL)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .threshold_average  (threshold_average),
    .value_in_concat    (value_in_concat),
    .value_ready_concat (value_ready_concat),
    .setup_done         (setup_done),
    .channel_over       (channel_over),
    .over_threshold     (over_threshold)
`ifdef MULTI_THRESHOLD_INTEGRATOR_PEAK_EN
    ,
    .peak_total_concat  (peak_total_concat)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Latch both channel magnitudes while idle, then raise enable; returns
  // just past E0.
  task automatic start_run(input logic [SW-1:0] v0, input logic [SW-1:0] v1,
                           input logic [SW-1:0] th);
    value_in_concat    = {v1, v0};
    value_ready_concat = 2'b11;
    threshold_average  = th;
    step(1);
    value_ready_concat = 2'b00;
    enable             = 1'b1;
    step(1);
  endtask

  task automatic stop_run();
    enable = 1'b0;
    step(1);
  endtask

  initial begin
    rst                = 1'b1;
    enable             = 1'b0;
    threshold_average  = '0;
    value_in_concat    = '0;
    value_ready_concat = '0;
    step(2);
    check("rst_setup_done", 64'(setup_done), 64'd0);
    check("rst_channel_over", 64'(channel_over), 64'd0);
    check("rst_over_threshold", 64'(over_threshold), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'd0);
    rst = 1'b0;
    step(1);

    // Magnitude 100 against limit 100*16=1600: equal, never trips.
    start_run(16'h8064, 16'h8000, 16'd100);
    check("below_setup_done", 64'(setup_done), 64'd1);
    step(16);
    check("below_total_b3", 64'(dut.g_ch[0].u_ch.total_q), 64'd1200);
    step(1);
    check("below_total_b4", 64'(dut.g_ch[0].u_ch.total_q), 64'd1600);
    step(40);
    check("below_total_settled", 64'(dut.g_ch[0].u_ch.total_q), 64'd1600);
    check("below_over", 64'(channel_over), 64'd0);
    check("below_state", 64'(dut.state_q), 64'd1);
    stop_run();

    // Threshold 99: limit 1584, the 4th boundary total 1600 trips at E17.
    start_run(16'h8064, 16'h8000, 16'd99);
    step(16);
    check("trip_over_early", 64'(channel_over), 64'd0);
    check("trip_state_early", 64'(dut.state_q), 64'd1);
    step(1);
    check("trip_over", 64'(channel_over), 64'd1);
    check("trip_state", 64'(dut.state_q), 64'd2);
    check("trip_over_threshold", 64'(over_threshold), 64'd1);
    check("trip_setup_done", 64'(setup_done), 64'd1);
    step(10);
    check("trip_sticky", 64'(channel_over), 64'd1);
    check("trip_state_hold", 64'(dut.state_q), 64'd2);
    stop_run();
    check("disable_over", 64'(channel_over), 64'd0);
    check("disable_setup_done", 64'(setup_done), 64'd0);
    check("disable_state", 64'(dut.state_q), 64'd0);
    check("disable_over_threshold", 64'(over_threshold), 64'd0);

    // ch1: magnitude 100 (below mid-scale) for 16 cycles, then 0; decays.
    start_run(16'h8000, 16'h7F9C, 16'd200);
    step(15);
    value_in_concat    = {16'h8000, 16'h8000};
    value_ready_concat = 2'b10;
    step(1);
    value_ready_concat = 2'b00;
    step(1);
    check("evict_total_peak", 64'(dut.g_ch[1].u_ch.total_q), 64'd1600);
    for (int k = 1; k <= 4; k++) begin
      step(4);
      check($sformatf("evict_total_%0d", k), 64'(dut.g_ch[1].u_ch.total_q),
            64'(1600 - 400 * k));
    end
    check("evict_ch0_total", 64'(dut.g_ch[0].u_ch.total_q), 64'd0);
    check("evict_over", 64'(channel_over), 64'd0);
`ifdef MULTI_THRESHOLD_INTEGRATOR_PEAK_EN
    check("peak_ch1", 64'(peak_total_concat[2*TW-1 -: TW]), 64'd1600);
    check("peak_ch0", 64'(peak_total_concat[TW-1 -: TW]), 64'd0);
`endif
    stop_run();

    // Both channels at full-scale magnitude 32768, limit 16: trip together at E5.
    start_run(16'h0000, 16'h0000, 16'd1);
    step(4);
    check("simul_over_early", 64'(channel_over), 64'd0);
    step(1);
    check("simul_over", 64'(channel_over), 64'd3);
    check("simul_state", 64'(dut.state_q), 64'd2);
    stop_run();
    check("simul_disable_over", 64'(channel_over), 64'd0);
    check("simul_disable_setup", 64'(setup_done), 64'd0);

    // Enable drops in the very cycle the trip is detected: IDLE wins.
    start_run(16'h0000, 16'h0000, 16'd1);
    step(4);
    enable = 1'b0;
    step(1);
    check("race_over", 64'(channel_over), 64'd0);
    check("race_state", 64'(dut.state_q), 64'd0);
    check("race_setup_done", 64'(setup_done), 64'd0);

    // Reset mid-run clears outputs at once and discards latched magnitudes.
    start_run(16'h8064, 16'h8000, 16'd99);
    step(6);
    rst = 1'b1;
    #1;
    check("midrst_setup_done", 64'(setup_done), 64'd0);
    check("midrst_over", 64'(channel_over), 64'd0);
    check("midrst_over_threshold", 64'(over_threshold), 64'd0);
    check("midrst_state", 64'(dut.state_q), 64'd0);
    check("midrst_total", 64'(dut.g_ch[0].u_ch.total_q), 64'd0);
    step(1);
    rst = 1'b0;
    step(20);
    check("postrst_setup_done", 64'(setup_done), 64'd1);
    check("postrst_total", 64'(dut.g_ch[0].u_ch.total_q), 64'd0);
    check("postrst_over", 64'(channel_over), 64'd0);
    stop_run();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
